pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; reset is synchronous and active-high.
REQ-004 SHALL have port redirect_valid, input, 1, meaning a jal/jalr/branch target is presented this cycle.
REQ-005 SHALL have port redirect_addr, input, 32, meaning the resolved jump target byte address.
REQ-006 SHALL have port stall, input, 1, meaning decode cannot accept the held instruction.
REQ-007 SHALL have port imem_req, output, 1, meaning an instruction memory read request.
REQ-008 SHALL have port imem_addr, output, 32, meaning the request address, held stable while imem_req=1 until imem_ack.
REQ-009 SHALL have port imem_ack, input, 1, meaning imem_rdata is valid and the request completes this cycle.
REQ-010 SHALL have port imem_rdata, input, 32, meaning the fetched instruction word.
REQ-011 SHALL have port inst_valid, output, 1, meaning inst, inst_pc and link_addr hold a valid fetched instruction.
REQ-012 SHALL have port inst, output, 32, meaning the registered instruction word.
REQ-013 SHALL have port inst_pc, output, 32, meaning the address inst was fetched from.
REQ-014 SHALL have port link_addr, output, 32, meaning inst_pc+4 (mod 2^32), the jal/jalr rd writeback value.
REQ-015 SHALL have port misalign_fault, output, 1, meaning a redirect target with bits [1:0] != 0 was rejected.

Function
REQ-016 SHALL implement FSM states BOOT, FETCH, HOLD, DRAIN, FAULT.
REQ-017 BOOT SHALL drive imem_req=0 and inst_valid=0, and SHALL go to FETCH on the next cycle with pc=RESET_VECTOR.
REQ-018 FETCH SHALL drive imem_req=1 and imem_addr=pc.
REQ-019 FETCH with imem_ack=1 and redirect_valid=0 SHALL register inst=imem_rdata and inst_pc=pc, set pc=pc+4, and go to HOLD (inst_valid=1 on the next cycle).
REQ-020 HOLD SHALL drive imem_req=0 and inst_valid=1; if stall=0, it SHALL go to FETCH and clear inst_valid next cycle; if stall=1, it SHALL keep all outputs unchanged.
REQ-021 redirect_valid SHALL take priority over stall and over any ack in every state except BOOT and FAULT.
REQ-022 A redirect in HOLD SHALL set pc=redirect_addr, clear inst_valid, and go to FETCH.
REQ-023 A redirect in FETCH with imem_ack=1 in the same cycle SHALL discard imem_rdata, set pc=redirect_addr, and remain in FETCH, so the next cycle requests the new address.
REQ-024 A redirect in FETCH with imem_ack=0 SHALL latch pending=redirect_addr and go to DRAIN, keeping imem_req=1 with the old imem_addr.
REQ-025 DRAIN SHALL ignore imem_rdata; on imem_ack it SHALL set pc=pending and go to FETCH; a further redirect in DRAIN SHALL overwrite pending (last wins).
REQ-026 pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000.
REQ-027 inst_valid SHALL never assert for a word whose request was outstanding when a redirect occurred.

Reset
REQ-028 rst=1 SHALL force state BOOT, pc=RESET_VECTOR, pending=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0, and misalign_fault=0 on the next edge.
REQ-029 Reset mid-request SHALL abandon the transaction; an imem_ack arriving in BOOT SHALL be ignored.

Configuration
REQ-030 Macro ALIGN_CHECK_EN SHALL control the handling of misaligned redirect targets.
REQ-031 With ALIGN_CHECK_EN defined, an accepted redirect with redirect_addr[1:0] != 0 SHALL not load pc and SHALL go to FAULT; FAULT SHALL drive imem_req=0, inst_valid=0, misalign_fault=1, and SHALL be left only by rst.
REQ-032 Without ALIGN_CHECK_EN, redirect_addr[1:0] SHALL be forced to 2'b00, the FAULT state SHALL be absent, and misalign_fault SHALL be tied to 0.

Structure
REQ-033 A shared package SHALL hold the state enum, the INST_BYTES=4 constant and the default reset vector.
REQ-034 The PC register with its load/increment/reset logic SHALL be one sub-module, pc_reg; the FSM and output registers SHALL stay in pc_fetch.

Verification
REQ-035 Reset then imem_ack on every request, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8; inst_valid every other cycle; link_addr=inst_pc+4.
REQ-036 HOLD with stall=1 for 5 cycles -> inst and inst_pc unchanged, imem_req=0; release -> next imem_addr=inst_pc+4.
REQ-037 Redirect to 0x100 while in FETCH, ack delayed 3 cycles -> imem_addr stays old until ack, that data is dropped, next imem_addr=0x100.
REQ-038 Redirect to 0x200 in the ack cycle, then a second redirect to 0x300 in DRAIN -> only 0x300 is fetched, no stale inst_valid.
REQ-039 pc=0xFFFF_FFFC fetched -> link_addr=0x0 and next imem_addr=0x0.
REQ-040 Redirect to 0x102: with ALIGN_CHECK_EN -> misalign_fault=1 and imem_req=0 until rst; without it -> imem_addr=0x100.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pc_fetch_pkg;

  localparam logic [31:0] INST_BYTES           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3
`ifdef ALIGN_CHECK_EN
    ,FAULT = 3'd4
`endif
  } state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_rsp_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset to the reset vector, load beats increment.
module pc_reg
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)       pc <= RESET_VECTOR;
    else if (load) pc <= load_addr;
    else if (inc)  pc <= pc + INST_BYTES;
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch FSM: one outstanding imem read, redirects drain stale responses.
// Build option ALIGN_CHECK_EN: misaligned redirects trap into FAULT instead of being truncated.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] link_addr,
  output logic        misalign_fault
);

  state_e      state, state_d;
  logic [31:0] pc, pending, pending_d, tgt;
  logic        pc_load, pc_inc, capture;
  logic [31:0] pc_load_addr;
  fetch_rsp_t  rsp;

  pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

`ifdef ALIGN_CHECK_EN
  assign tgt = redirect_addr;
`else
  assign tgt = redirect_addr & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_d      = state;
    pending_d    = pending;
    pc_load      = 1'b0;
    pc_load_addr = tgt;
    pc_inc       = 1'b0;
    capture      = 1'b0;
    case (state)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (redirect_valid) begin
          // With the ack already here nothing is outstanding, so refetch at once
          if (imem_ack) pc_load = 1'b1;
          else begin
            pending_d = tgt;
            state_d   = DRAIN;
          end
        end else if (imem_ack) begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end else if (!stall) state_d = FETCH;
      end
      DRAIN: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            pc_load = 1'b1;
            state_d = FETCH;
          end else pending_d = tgt;
        end else if (imem_ack) begin
          pc_load      = 1'b1;
          pc_load_addr = pending;
          state_d      = FETCH;
        end
      end
`ifdef ALIGN_CHECK_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = BOOT;
    endcase
`ifdef ALIGN_CHECK_EN
    if (redirect_valid && (redirect_addr[1:0] != 2'b00) &&
        (state == FETCH || state == HOLD || state == DRAIN)) begin
      state_d   = FAULT;
      pending_d = pending;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      capture   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pending    <= 32'h0;
      inst_valid <= 1'b0;
      rsp        <= '0;
    end else begin
      state      <= state_d;
      pending    <= pending_d;
      inst_valid <= (state_d == HOLD);
      if (capture) rsp <= '{word: imem_rdata, pc: pc};
    end
  end

  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = pc;
  assign inst      = rsp.word;
  assign inst_pc   = rsp.pc;
  assign link_addr = rsp.pc + INST_BYTES;

`ifdef ALIGN_CHECK_EN
  assign misalign_fault = (state == FAULT);
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; honours ALIGN_CHECK_EN for the misaligned-redirect step.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, stall, imem_ack;
  logic [31:0] redirect_addr, imem_rdata;
  logic        imem_req, inst_valid, misalign_fault;
  logic [31:0] imem_addr, inst, inst_pc, link_addr;

  int checks = 0;
  int errors = 0;

  pc_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .link_addr      (link_addr),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] ra, input logic st,
                       input logic ack, input logic [31:0] rd);
    redirect_valid = rv; redirect_addr = ra; stall = st; imem_ack = ack; imem_rdata = rd;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst",  inst, 32'h0);
    chk("rst_pc",    inst_pc, 32'h0);
    chk("rst_fault", {31'b0, misalign_fault}, 32'd0);

    // BOOT -> FETCH at the reset vector
    rst = 1'b0;
    tick();
    chk("boot_req",  {31'b0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);

    // Straight-line fetch
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0000);
    tick();
    chk("f0_valid", {31'b0, inst_valid}, 32'd1);
    chk("f0_inst",  inst, 32'hA000_0000);
    chk("f0_pc",    inst_pc, 32'h0);
    chk("f0_link",  link_addr, 32'h4);
    chk("f0_req",   {31'b0, imem_req}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("f1_addr",  imem_addr, 32'h4);
    chk("f1_valid", {31'b0, inst_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0001);
    tick();
    chk("f1_inst",  inst, 32'hA000_0001);
    chk("f1_link",  link_addr, 32'h8);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("f2_addr",  imem_addr, 32'h8);

    // Stall in HOLD
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0002);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst",  inst, 32'hA000_0002);
      chk("stall_pc",    inst_pc, 32'h8);
      chk("stall_req",   {31'b0, imem_req}, 32'd0);
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_addr", imem_addr, 32'hC);

    // Redirect with the ack 3 cycles late
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    tick();
    chk("drain_req",  {31'b0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'hC);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("drain_hold_addr", imem_addr, 32'hC);
    chk("drain_valid",     {31'b0, inst_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_DEAD);
    tick();
    chk("drop_valid", {31'b0, inst_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hB000_0000);
    tick();
    chk("redir_inst", inst, 32'hB000_0000);
    chk("redir_pc",   inst_pc, 32'h100);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("post_redir_addr", imem_addr, 32'h104);

    // Redirect in the ack cycle, then redirect twice while draining
    drive(1'b1, 32'h180, 1'b0, 1'b1, 32'hBAD0_0001);
    tick();
    chk("ackredir_valid", {31'b0, inst_valid}, 32'd0);
    chk("ackredir_addr",  imem_addr, 32'h180);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    tick();
    chk("d2_addr", imem_addr, 32'h180);
    drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    tick();
    chk("d3_addr",  imem_addr, 32'h180);
    chk("d3_valid", {31'b0, inst_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0002);
    tick();
    chk("last_wins_addr",  imem_addr, 32'h300);
    chk("last_wins_valid", {31'b0, inst_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000);
    tick();
    chk("f300_pc",   inst_pc, 32'h300);
    chk("f300_inst", inst, 32'hC000_0000);

    // Redirect beats stall in HOLD, then wrap at the top of memory
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    tick();
    chk("holdredir_valid", {31'b0, inst_valid}, 32'd0);
    chk("holdredir_addr",  imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hD000_0000);
    tick();
    chk("wrap_pc",   inst_pc, 32'hFFFF_FFFC);
    chk("wrap_link", link_addr, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);

    // Misaligned redirect from HOLD
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hE000_0000);
    tick();
    drive(1'b1, 32'h102, 1'b0, 1'b0, 32'h0);
    tick();
`ifdef ALIGN_CHECK_EN
    chk("fault_flag",  {31'b0, misalign_fault}, 32'd1);
    chk("fault_req",   {31'b0, imem_req}, 32'd0);
    chk("fault_valid", {31'b0, inst_valid}, 32'd0);
    drive(1'b1, 32'h400, 1'b0, 1'b1, 32'h0);
    tick(); tick();
    chk("fault_sticky", {31'b0, misalign_fault}, 32'd1);
    chk("fault_req2",   {31'b0, imem_req}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    chk("fault_clr", {31'b0, misalign_fault}, 32'd0);
    rst = 1'b0;
    tick();
    chk("fault_refetch", imem_addr, 32'h0);
`else
    chk("align_addr",  imem_addr, 32'h100);
    chk("align_fault", {31'b0, misalign_fault}, 32'd0);
    chk("align_req",   {31'b0, imem_req}, 32'd1);
`endif

    // Reset mid-request; ack landing in BOOT must be ignored
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0003);
    tick();
    chk("bootack_valid", {31'b0, inst_valid}, 32'd0);
    chk("bootack_addr",  imem_addr, 32'h0);
    chk("bootack_inst",  inst, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
